weight_fifo_loader: RTL and testbench

Upstream feeder for the dual-column weight FIFO. Accepts a byte stream of weights over a valid/ready handshake, steers bytes alternately onto the FIFO's shared data bus with column push strobes, and tracks per-column occupancy so the FIFO never overflows. On request, it drives the pop sequence that loads one weight tile into the MMU. It also generates per-column weight-load enables aligned to the FIFO's unskewed column 0 and 1-cycle-skewed column 1 outputs.

---
 rtl/weight_fifo_loader.sv | 192 +++++++++++++++++++
 tb/tb_weight_fifo_loader.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_fifo_loader.sv
// weight_fifo_loader: feeds a dual-column weight FIFO from a byte stream and
// sequences tile loads (pops) into the MMU with column-aligned latch enables.
module weight_fifo_loader #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned ROWS  = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       s_valid,
  input  logic [7:0] s_data,
  output logic       s_ready,
  input  logic       load_req,
  output logic       push_col0,
  output logic       push_col1,
  output logic [7:0] data_out,
  output logic       pop,
  output logic       wl_en_col0,
  output logic       wl_en_col1,
  output logic       load_busy,
  output logic       load_done,
  output logic       tile_avail
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] ROWS_C   = CW'(ROWS);
  localparam logic [PW-1:0] LAST_POP = PW'(ROWS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    SKEW = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [PW-1:0]   pop_cnt;
  logic [PW-1:0]   pop_cnt_next;
  logic            sel;
  logic [CW-1:0]   res0;
  logic [CW-1:0]   res1;
  logic [CW-1:0]   com0;
  logic [CW-1:0]   com1;
  logic            accept;
  logic            start;

  // Readiness looks only at the selected column's current reservation; a
  // pop in this same cycle does not open a slot until the next cycle.
  assign s_ready    = sel ? (res1 < DEPTH_C) : (res0 < DEPTH_C);
  assign accept     = s_valid & s_ready;
  assign tile_avail = (com0 >= ROWS_C) && (com1 >= ROWS_C);
  assign start      = load_req & tile_avail & ~push_col0 & ~push_col1;
  assign wl_en_col0 = pop;

  // Steering bit: alternates columns on every accepted byte.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sel <= 1'b0;
    end else if (accept) begin
      sel <= ~sel;
    end
  end

  // Registered write port toward the FIFO; data bus holds when idle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      push_col0 <= 1'b0;
      push_col1 <= 1'b0;
      data_out  <= '0;
    end else begin
      push_col0 <= accept & ~sel;
      push_col1 <= accept & sel;
      if (accept) begin
        data_out <= s_data;
      end
    end
  end

  // Reserved count, column 0: bumped at accept time, released by pops.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      res0 <= '0;
    end else begin
      case ({accept & ~sel, pop})
        2'b10:   res0 <= res0 + CW'(1);
        2'b01:   res0 <= res0 - CW'(1);
        default: res0 <= res0;
      endcase
    end
  end

  // Reserved count, column 1.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      res1 <= '0;
    end else begin
      case ({accept & sel, pop})
        2'b10:   res1 <= res1 + CW'(1);
        2'b01:   res1 <= res1 - CW'(1);
        default: res1 <= res1;
      endcase
    end
  end

  // Committed count, column 0: follows writes that actually land in the FIFO.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      com0 <= '0;
    end else begin
      case ({push_col0, pop})
        2'b10:   com0 <= com0 + CW'(1);
        2'b01:   com0 <= com0 - CW'(1);
        default: com0 <= com0;
      endcase
    end
  end

  // Committed count, column 1.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      com1 <= '0;
    end else begin
      case ({push_col1, pop})
        2'b10:   com1 <= com1 + CW'(1);
        2'b01:   com1 <= com1 - CW'(1);
        default: com1 <= com1;
      endcase
    end
  end

  // Load sequencer state and pop counter registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      pop_cnt <= '0;
    end else begin
      state   <= state_next;
      pop_cnt <= pop_cnt_next;
    end
  end

  // Column 1 leaves the FIFO one cycle behind column 0.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wl_en_col1 <= 1'b0;
    end else begin
      wl_en_col1 <= pop;
    end
  end

  // Next-state and load outputs: ROWS pop cycles, then one skew cycle.
  always_comb begin
    state_next   = state;
    pop_cnt_next = pop_cnt;
    pop          = 1'b0;
    load_busy    = 1'b0;
    load_done    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next   = POP;
          pop_cnt_next = '0;
        end
      end
      POP: begin
        pop       = 1'b1;
        load_busy = 1'b1;
        if (pop_cnt == LAST_POP) begin
          state_next = SKEW;
        end else begin
          pop_cnt_next = pop_cnt + PW'(1);
        end
      end
      SKEW: begin
        load_busy  = 1'b1;
        load_done  = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Occupancy sanity: never pop an empty column, never over-reserve.
  a_no_underflow: assert property (@(posedge clk) disable iff (!reset_n)
    pop |-> ((com0 != '0) && (com1 != '0)));
  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    (res0 <= DEPTH_C) && (res1 <= DEPTH_C));

endmodule

// File: tb/tb_weight_fifo_loader.sv
// Bench for weight_fifo_loader: a queue-based reference model of the FIFO
// contents plus a load-timeline age counter predicts every output each cycle.
module tb_weight_fifo_loader;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned ROWS  = 2;
  localparam logic [16:0] RESET_VEC = 17'h10000;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       load_req = 1'b0;
  logic       s_ready, push_col0, push_col1, pop;
  logic       wl_en_col0, wl_en_col1, load_busy, load_done, tile_avail;
  logic [7:0] data_out;
  logic [16:0] out_vec;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  weight_fifo_loader #(.DEPTH(DEPTH), .ROWS(ROWS)) dut (
    .clk(clk), .reset_n(reset_n), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .load_req(load_req), .push_col0(push_col0),
    .push_col1(push_col1), .data_out(data_out), .pop(pop),
    .wl_en_col0(wl_en_col0), .wl_en_col1(wl_en_col1),
    .load_busy(load_busy), .load_done(load_done), .tile_avail(tile_avail)
  );

  assign out_vec = {s_ready, push_col0, push_col1, data_out, pop, wl_en_col0,
                    wl_en_col1, load_busy, load_done, tile_avail};

  // Reference model: committed FIFO contents, one in-flight byte, and the
  // number of cycles since a tile load started (0 = no load running).
  bit         m_sel = 1'b0;
  logic [7:0] mq0[$];
  logic [7:0] mq1[$];
  bit         m_pend = 1'b0;
  bit         m_pend_col = 1'b0;
  logic [7:0] m_last = 8'h00;
  int         m_age = 0;

  function automatic int m_res(input bit col);
    if (col) return mq1.size() + ((m_pend && m_pend_col) ? 1 : 0);
    return mq0.size() + ((m_pend && !m_pend_col) ? 1 : 0);
  endfunction

  function automatic bit m_ready();
    return m_res(m_sel) < DEPTH;
  endfunction

  function automatic bit m_avail();
    return (mq0.size() >= ROWS) && (mq1.size() >= ROWS);
  endfunction

  function automatic logic [16:0] exp_vec();
    bit popping;
    popping = (m_age >= 1) && (m_age <= ROWS);
    return {m_ready(), m_pend && !m_pend_col, m_pend && m_pend_col, m_last,
            popping, popping, (m_age >= 2) && (m_age <= ROWS + 1),
            m_age >= 1, m_age == ROWS + 1, m_avail()};
  endfunction

  always @(posedge clk) begin
    if (!reset_n) begin
      m_sel = 1'b0; mq0.delete(); mq1.delete();
      m_pend = 1'b0; m_pend_col = 1'b0; m_last = 8'h00; m_age = 0;
    end else begin
      bit acc;
      bit go;
      acc = s_valid && m_ready();
      go  = (m_age == 0) && load_req && m_avail() && !m_pend;
      if (m_age >= 1 && m_age <= ROWS) begin
        if (mq0.size() > 0) void'(mq0.pop_front());
        if (mq1.size() > 0) void'(mq1.pop_front());
      end
      if (m_pend) begin
        if (m_pend_col) mq1.push_back(m_last);
        else            mq0.push_back(m_last);
      end
      m_pend = acc;
      m_pend_col = m_sel;
      if (acc) begin
        m_last = s_data;
        m_sel  = !m_sel;
      end
      if (go)                   m_age = 1;
      else if (m_age == ROWS+1) m_age = 0;
      else if (m_age > 0)       m_age = m_age + 1;
    end
  end

  // FIFO built from the DUT's own write/pop strobes; popped entries must
  // match the model's column contents.
  logic [7:0] dq0[$];
  logic [7:0] dq1[$];
  logic [7:0] pop0_log[$];
  logic [7:0] pop1_log[$];

  always @(negedge clk) begin
    logic [7:0] got, want;
    if (pop === 1'b1) begin
      got  = (dq0.size() > 0) ? dq0.pop_front() : 8'h00;
      want = (mq0.size() > 0) ? mq0[0] : 8'h00;
      pop0_log.push_back(got);
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL col0_data t=%0t got=%h exp=%h", $time, got, want);
      end
      got  = (dq1.size() > 0) ? dq1.pop_front() : 8'h00;
      want = (mq1.size() > 0) ? mq1[0] : 8'h00;
      pop1_log.push_back(got);
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL col1_data t=%0t got=%h exp=%h", $time, got, want);
      end
    end
    if (push_col0 === 1'b1) dq0.push_back(data_out);
    if (push_col1 === 1'b1) dq1.push_back(data_out);
    if (reset_n === 1'b0) begin
      dq0.delete();
      dq1.delete();
    end
  end

  // Apply one cycle of inputs just after the edge, return at the mid-cycle
  // sampling point.
  task automatic tick(input bit v, input logic [7:0] d, input bit lr, input bit rn);
    @(posedge clk);
    #1;
    s_valid = v; s_data = d; load_req = lr; reset_n = rn;
    @(negedge clk);
  endtask

  task automatic test_reset();
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    vectors++;
    if (out_vec !== RESET_VEC) begin
      miscompares++;
      $display("FAIL reset_state got=%h exp=%h", out_vec, RESET_VEC);
    end
    tick(1'b0, 8'h00, 1'b0, 1'b1);
    vectors++;
    if (out_vec !== exp_vec()) begin
      miscompares++;
      $display("FAIL reset_release got=%h exp=%h", out_vec, exp_vec());
    end
  endtask

  task automatic test_basic();
    logic [7:0] bytes [4];
    int i, last_acc, avail_cyc, done_cyc, first_pop;
    bytes = '{8'h11, 8'h21, 8'h12, 8'h22};
    i = 0; last_acc = -1; avail_cyc = -1; done_cyc = -1; first_pop = -1;
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    pop0_log.delete(); pop1_log.delete();
    for (int c = 0; c < 14; c++) begin
      tick(i < 4, bytes[i % 4], 1'b1, 1'b1);
      vectors++;
      if (out_vec !== exp_vec()) begin
        miscompares++;
        $display("FAIL basic c=%0d got=%h exp=%h", c, out_vec, exp_vec());
      end
      if (s_valid && s_ready) begin i++; last_acc = c; end
      if (tile_avail && avail_cyc < 0) avail_cyc = c;
      if (pop && first_pop < 0) first_pop = c;
      if (load_done && done_cyc < 0) done_cyc = c;
    end
    vectors++;
    if (avail_cyc !== last_acc + 2) begin
      miscompares++;
      $display("FAIL basic_avail_latency got=%0d exp=%0d", avail_cyc, last_acc + 2);
    end
    vectors++;
    if (first_pop < 0 || done_cyc !== first_pop + ROWS) begin
      miscompares++;
      $display("FAIL basic_done_cycle got=%0d exp=%0d", done_cyc, first_pop + ROWS);
    end
    vectors++;
    if (pop0_log.size() != 2 || pop0_log[0] !== 8'h11 || pop0_log[1] !== 8'h12) begin
      miscompares++;
      $display("FAIL basic_col0_tile got=%p exp=11,12", pop0_log);
    end
    vectors++;
    if (pop1_log.size() != 2 || pop1_log[0] !== 8'h21 || pop1_log[1] !== 8'h22) begin
      miscompares++;
      $display("FAIL basic_col1_tile got=%p exp=21,22", pop1_log);
    end
  endtask

  task automatic test_full();
    int acc, first_pop, ready_back;
    acc = 0; first_pop = -1; ready_back = -1;
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    for (int c = 0; c < 20; c++) begin
      tick(1'b1, 8'h30 + 8'(acc), c >= 12, 1'b1);
      vectors++;
      if (out_vec !== exp_vec()) begin
        miscompares++;
        $display("FAIL full c=%0d got=%h exp=%h", c, out_vec, exp_vec());
      end
      if (first_pop >= 0 && ready_back < 0 && s_ready) ready_back = c;
      if (pop && first_pop < 0) first_pop = c;
      if (s_valid && s_ready) acc++;
      if (c == 11) begin
        vectors++;
        if (acc != 8) begin
          miscompares++;
          $display("FAIL full_accept_count got=%0d exp=8", acc);
        end
      end
    end
    vectors++;
    if (first_pop < 0 || ready_back !== first_pop + 1) begin
      miscompares++;
      $display("FAIL full_ready_return got=%0d exp=%0d", ready_back, first_pop + 1);
    end
  endtask

  task automatic test_partial();
    int sent, early_pops, a4, first_pop;
    sent = 0; early_pops = 0; a4 = -1; first_pop = -1;
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    for (int c = 0; c < 16; c++) begin
      tick((sent < 3) || (c >= 9 && sent < 4), 8'h60 + 8'(sent), 1'b1, 1'b1);
      vectors++;
      if (out_vec !== exp_vec()) begin
        miscompares++;
        $display("FAIL partial c=%0d got=%h exp=%h", c, out_vec, exp_vec());
      end
      if (pop && c < 9) early_pops++;
      if (pop && first_pop < 0) first_pop = c;
      if (s_valid && s_ready) begin
        if (sent == 3) a4 = c;
        sent++;
      end
    end
    vectors++;
    if (early_pops != 0) begin
      miscompares++;
      $display("FAIL partial_no_pop got=%0d exp=0", early_pops);
    end
    // start condition is seen at accept+2, the first pop one cycle later
    vectors++;
    if (a4 < 0 || first_pop !== a4 + 3) begin
      miscompares++;
      $display("FAIL partial_pop_start got=%0d exp=%0d", first_pop, a4 + 3);
    end
  endtask

  task automatic test_stream_during_pop();
    int collisions;
    collisions = 0;
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    for (int c = 0; c < 30; c++) begin
      tick((c < 6) || (c >= 9), 8'h80 + 8'(c), c >= 9, 1'b1);
      vectors++;
      if (out_vec !== exp_vec()) begin
        miscompares++;
        $display("FAIL stream_pop c=%0d got=%h exp=%h", c, out_vec, exp_vec());
      end
      if (push_col0 && pop) collisions++;
    end
    vectors++;
    if (collisions == 0) begin
      miscompares++;
      $display("FAIL stream_pop_collision got=%0d exp=>0", collisions);
    end
  endtask

  task automatic test_back_to_back();
    int starts[$];
    bit prev;
    prev = 1'b0;
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    for (int c = 0; c < 22; c++) begin
      tick(c < 8, 8'hA0 + 8'(c), c >= 8, 1'b1);
      vectors++;
      if (out_vec !== exp_vec()) begin
        miscompares++;
        $display("FAIL b2b c=%0d got=%h exp=%h", c, out_vec, exp_vec());
      end
      if (pop && !prev) starts.push_back(c);
      prev = pop;
    end
    vectors++;
    if (starts.size() != 2 || starts[1] - starts[0] != ROWS + 2) begin
      miscompares++;
      $display("FAIL b2b_spacing got=%p exp=gap %0d", starts, ROWS + 2);
    end
  endtask

  task automatic test_mid_reset();
    int sent, pops_seen, rst_cyc, dones;
    bit rn;
    sent = 0; pops_seen = 0; rst_cyc = -10; dones = 0;
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    for (int c = 0; c < 24; c++) begin
      rn = !(pops_seen == 1 && rst_cyc < 0);
      if (!rn) rst_cyc = c;
      tick((sent < 4) || (c == rst_cyc + 1), (c == rst_cyc + 1) ? 8'h5A : 8'hC0 + 8'(sent),
           rst_cyc < 0, rn);
      vectors++;
      if (out_vec !== exp_vec()) begin
        miscompares++;
        $display("FAIL mid_reset c=%0d got=%h exp=%h", c, out_vec, exp_vec());
      end
      if (c == rst_cyc + 1) begin
        vectors++;
        if (out_vec !== RESET_VEC) begin
          miscompares++;
          $display("FAIL mid_reset_values got=%h exp=%h", out_vec, RESET_VEC);
        end
      end
      if (c == rst_cyc + 2) begin
        vectors++;
        if (push_col0 !== 1'b1 || push_col1 !== 1'b0 || data_out !== 8'h5A) begin
          miscompares++;
          $display("FAIL mid_reset_steer got=%b%b/%h exp=10/5a", push_col0, push_col1, data_out);
        end
      end
      if (pop) pops_seen++;
      if (load_done) dones++;
      if (s_valid && s_ready && sent < 4) sent++;
    end
    vectors++;
    if (rst_cyc < 0 || dones != 0) begin
      miscompares++;
      $display("FAIL mid_reset_no_done got=%0d exp=0 (reset at %0d)", dones, rst_cyc);
    end
  endtask

  task automatic test_random();
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    for (int c = 0; c < 1500; c++) begin
      tick($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 3) != 0,
           $urandom_range(0, 199) != 0);
      vectors++;
      if (out_vec !== exp_vec()) begin
        miscompares++;
        $display("FAIL random c=%0d got=%h exp=%h", c, out_vec, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_partial();
    test_stream_during_pop();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
